// File: rtl/host_sequencer.sv
// Host run sequencer: optional data-memory preload, timed DutStart pulse, and run
// supervision with ack/timeout. Define HOST_SEQ_PRELOAD_EN to enable the LOAD phase.
module host_sequencer #(
   parameter int unsigned START_CYCLES = 2,
   parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Go,
   input  logic [1:0]  ProgSel,
   input  logic        LdValid,
   output logic        LdReady,
   input  logic        LdLast,
   input  logic [7:0]  LdAddr,
   input  logic [7:0]  LdData,
   output logic        DmWrEn,
   output logic [7:0]  DmAddr,
   output logic [7:0]  DmData,
   output logic        DutStart,
   output logic [1:0]  DutProgSel,
   input  logic        DutAck,
   output logic        Busy,
   output logic        Done,
   output logic        TimedOut,
   output logic [15:0] RunCycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

   state_t      r_state,      w_state_nxt;
   logic [3:0]  r_start_cnt,  w_start_cnt_nxt;
   logic [1:0]  r_prog_sel,   w_prog_sel_nxt;
   logic [15:0] r_run_cycles, w_run_cycles_nxt;
   logic        r_timed_out,  w_timed_out_nxt;
   logic        r_dm_wr_en,   w_dm_wr_en_nxt;
   logic [7:0]  r_dm_addr,    w_dm_addr_nxt;
   logic [7:0]  r_dm_data,    w_dm_data_nxt;
   logic        r_dut_start,  w_dut_start_nxt;
   logic        r_busy,       w_busy_nxt;
   logic        r_done,       w_done_nxt;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_start_cnt_nxt  = r_start_cnt;
      w_prog_sel_nxt   = r_prog_sel;
      w_run_cycles_nxt = r_run_cycles;
      w_timed_out_nxt  = r_timed_out;
      w_dm_wr_en_nxt   = 1'b0;
      w_dm_addr_nxt    = r_dm_addr;
      w_dm_data_nxt    = r_dm_data;

      case (r_state)
         S_IDLE: begin
            if (Go) begin
               w_prog_sel_nxt   = ProgSel;
               w_run_cycles_nxt = '0;
               w_timed_out_nxt  = 1'b0;
               w_start_cnt_nxt  = '0;
`ifdef HOST_SEQ_PRELOAD_EN
               w_state_nxt      = S_LOAD;
`else
               w_state_nxt      = S_START;
`endif
            end
         end

         S_LOAD: begin
`ifdef HOST_SEQ_PRELOAD_EN
            if (LdValid) begin
               w_dm_wr_en_nxt = 1'b1;
               w_dm_addr_nxt  = LdAddr;
               w_dm_data_nxt  = LdData;
               if (LdLast) begin
                  w_state_nxt = S_START;
               end
            end
`else
            w_state_nxt = S_IDLE;
`endif
         end

         S_START: begin
            if (r_start_cnt == START_LAST) begin
               w_state_nxt = S_RUN;
            end else begin
               w_start_cnt_nxt = r_start_cnt + 4'd1;
            end
         end

         // Ack is checked before the limit so a simultaneous ack is never reported as a timeout.
         S_RUN: begin
            if (DutAck) begin
               w_state_nxt = S_DONE;
            end else if (r_run_cycles == TIMEOUT) begin
               w_state_nxt     = S_DONE;
               w_timed_out_nxt = 1'b1;
            end else begin
               w_run_cycles_nxt = r_run_cycles + 16'd1;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_dut_start_nxt = (w_state_nxt == S_START);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_done_nxt      = (w_state_nxt == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_start_cnt  <= '0;
         r_prog_sel   <= '0;
         r_run_cycles <= '0;
         r_timed_out  <= 1'b0;
         r_dm_wr_en   <= 1'b0;
         r_dm_addr    <= '0;
         r_dm_data    <= '0;
         r_dut_start  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_start_cnt  <= w_start_cnt_nxt;
         r_prog_sel   <= w_prog_sel_nxt;
         r_run_cycles <= w_run_cycles_nxt;
         r_timed_out  <= w_timed_out_nxt;
         r_dm_wr_en   <= w_dm_wr_en_nxt;
         r_dm_addr    <= w_dm_addr_nxt;
         r_dm_data    <= w_dm_data_nxt;
         r_dut_start  <= w_dut_start_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
      end
   end

`ifdef HOST_SEQ_PRELOAD_EN
   assign LdReady = (r_state == S_LOAD);
`else
   logic w_unused_ld;
   assign w_unused_ld = ^{LdValid, LdLast, LdAddr, LdData};
   assign LdReady     = 1'b0;
`endif

   assign DmWrEn     = r_dm_wr_en;
   assign DmAddr     = r_dm_addr;
   assign DmData     = r_dm_data;
   assign DutStart   = r_dut_start;
   assign DutProgSel = r_prog_sel;
   assign Busy       = r_busy;
   assign Done       = r_done;
   assign TimedOut   = r_timed_out;
   assign RunCycles  = r_run_cycles;

endmodule

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2, giving the DutStart pulse width in cycles (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, giving the maximum RUN cycles before abort.
REQ-003 SHALL have these ports:
- Clk  in  1  sole clock, posedge
- Reset  in  1  asynchronous, active-high
- Go  in  1  host run request
- ProgSel  in  2  program index, sampled with Go
- LdValid  in  1  preload word valid
- LdReady  out  1  preload word accepted
- LdLast  in  1  final preload word
- LdAddr  in  8  data-memory address
- LdData  in  8  data-memory word
- DmWrEn  out  1  data-memory write enable
- DmAddr  out  8  data-memory write address
- DmData  out  8  data-memory write data
- DutStart  out  1  processor Start
- DutProgSel  out  2  latched program index
- DutAck  in  1  processor done flag
- Busy  out  1  sequence in progress
- Done  out  1  one-cycle completion pulse
- TimedOut  out  1  last run aborted
- RunCycles  out  16  cycles spent in RUN

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, START, RUN, DONE; all outputs registered except LdReady.
REQ-005 IDLE: Busy=0, LdReady=0; Go=1 latches ProgSel into DutProgSel, clears RunCycles and TimedOut, goes to LOAD.
REQ-006 Go SHALL be ignored in every state other than IDLE.
REQ-007 LOAD: LdReady=1 (combinational from state); each cycle with LdValid=1 SHALL register DmWrEn=1, DmAddr=LdAddr, DmData=LdData on the next edge; otherwise DmWrEn=0.
REQ-008 LOAD: the accepted beat with LdLast=1 SHALL move to START; LdLast with LdValid=0 SHALL be ignored.
REQ-009 START: DutStart=1 for exactly START_CYCLES cycles, then go to RUN with DutStart=0; DutAck SHALL be ignored in START.
REQ-010 RUN: RunCycles SHALL increment by 1 each cycle, starting from 0 in the first RUN cycle.
REQ-011 RUN: when DutAck=1 is sampled, go to DONE with RunCycles frozen and TimedOut=0.
REQ-012 RUN: when RunCycles==TIMEOUT with DutAck=0, go to DONE with TimedOut=1; RunCycles SHALL saturate and never wrap.
REQ-013 RUN: when DutAck=1 and RunCycles==TIMEOUT in the same cycle, Ack SHALL win (TimedOut=0).
REQ-014 DONE: Done=1 for one cycle, then go to IDLE; RunCycles, TimedOut, and DutProgSel SHALL hold until the next accepted Go.
REQ-015 Busy SHALL be 1 in LOAD, START, RUN, and DONE.

Reset
REQ-016 Reset=1 SHALL immediately force IDLE and set all outputs to 0 (DutStart=0, DmWrEn=0, Done=0, TimedOut=0, RunCycles=0, DutProgSel=0), including mid-LOAD or mid-RUN.
REQ-017 A preload transfer interrupted by Reset SHALL be discarded, with no further DmWrEn pulses after Reset asserts.

Configuration
REQ-018 Macro HOST_SEQ_PRELOAD_EN defined: the LOAD state and preload ports behave per REQ-007/008.
REQ-019 Macro HOST_SEQ_PRELOAD_EN undefined: an accepted Go in IDLE SHALL go directly to START; LdReady and DmWrEn are tied to 0; Ld* inputs are ignored.

Verification
REQ-020 Go=1, ProgSel=2, three preload beats (last with LdLast), DutAck rising 10 cycles after DutStart falls -> three DmWrEn pulses with matching addr/data, DutStart high 2 cycles, DutProgSel=2, RunCycles=10, one Done pulse, TimedOut=0.
REQ-021 TIMEOUT=20, DutAck held 0 -> DONE after RUN reaches 20, TimedOut=1, RunCycles=20, Done pulses once.
REQ-022 DutAck=1 throughout START -> ignored; DONE on the first RUN cycle with RunCycles=0.
REQ-023 Go pulsed during RUN -> no effect; DutProgSel unchanged.
REQ-024 Reset asserted mid-LOAD after one beat -> outputs 0 within the same cycle; a subsequent Go restarts at LOAD cleanly.
REQ-025 Build without HOST_SEQ_PRELOAD_EN, Go=1 -> DutStart rises on the next edge; LdReady stays 0.
